// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a byte-addressed little-endian 32-bit data memory.
// Sub-word stores are done as read-modify-write because the memory always writes a full word.
module mem_access_unit #(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_din,
  output logic        mem_mrd,
  output logic        mem_mwr,
  input  logic [31:0] mem_dout
);

  localparam logic [31:0] MAX_ADR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] adr_q, wdata_q, data_q, rdata_q;
  logic [1:0]  size_q;
  logic        we_q, uns_q, err_q;
  logic        req_legal;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        uns);
    case (size)
      2'b00:   load_extend = uns ? {24'd0, word[7:0]}  : {{24{word[7]}}, word[7:0]};
      2'b01:   load_extend = uns ? {16'd0, word[15:0]} : {{16{word[15]}}, word[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size);
    case (size)
      2'b00:   store_merge = {old_word[31:8], wdata[7:0]};
      2'b01:   store_merge = {old_word[31:16], wdata[15:0]};
      default: store_merge = wdata;
    endcase
  endfunction

  // Unsigned 32-bit compare: addresses near 2^32 must not wrap into range.
  assign req_legal = (req_size != 2'b11) && (req_adr <= MAX_ADR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_mrd   = 1'b0;
    mem_mwr   = 1'b0;
    mem_adr   = '0;
    mem_din   = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!req_legal)                         state_nxt = RESP;
          else if (!req_we || req_size != 2'b10)  state_nxt = RD;
          else                                    state_nxt = WR;
        end
      end
      RD: begin
        mem_mrd   = 1'b1;
        mem_adr   = adr_q;
        state_nxt = we_q ? WR : RESP;
      end
      WR: begin
        mem_mwr   = 1'b1;
        mem_adr   = adr_q;
        mem_din   = store_merge(data_q, wdata_q, size_q);
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q   <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            adr_q   <= req_adr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            err_q   <= !req_legal;
            rdata_q <= '0;
          end
        end
        RD: begin
          data_q <= mem_dout;
          if (!we_q) rdata_q <= load_extend(mem_dout, size_q, uns_q);
        end
        RESP: begin
          if (rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory model, fixed vector table,
// randomized traffic against a byte-level reference model, and corner sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_adr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_adr, mem_din, mem_dout;
  logic        mem_mrd, mem_mwr;

  int checks = 0;
  int errors = 0;
  int mrd_cnt = 0, mwr_cnt = 0, overlap_cnt = 0;
  logic [31:0] last_din = '0;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(65536)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_adr(req_adr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_adr(mem_adr), .mem_din(mem_din), .mem_mrd(mem_mrd), .mem_mwr(mem_mwr),
    .mem_dout(mem_dout)
  );

  // Memory: combinational read, write on the clock edge.
  always_comb begin
    mem_dout = '0;
    if (mem_mrd && mem_adr <= 32'd65532)
      mem_dout = {mem[mem_adr[15:0] + 16'd3], mem[mem_adr[15:0] + 16'd2],
                  mem[mem_adr[15:0] + 16'd1], mem[mem_adr[15:0]]};
  end

  always @(posedge clk) begin
    if (mem_mwr && mem_adr <= 32'd65532) begin
      mem[mem_adr[15:0]]         <= mem_din[7:0];
      mem[mem_adr[15:0] + 16'd1] <= mem_din[15:8];
      mem[mem_adr[15:0] + 16'd2] <= mem_din[23:16];
      mem[mem_adr[15:0] + 16'd3] <= mem_din[31:24];
    end
  end

  always @(negedge clk) begin
    if (mem_mrd) mrd_cnt++;
    if (mem_mwr) begin
      mwr_cnt++;
      last_din = mem_din;
    end
    if (mem_mrd && mem_mwr) overlap_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference: legality, latency and data derived from byte-level rules.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] adr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err, output int lat,
                                output int nrd, output int nwr, output logic [31:0] din);
    int nbytes;
    logic [31:0] word;
    rd = 0; din = 0; nrd = 0; nwr = 0;
    err = (size == 2'b11) || (adr > 32'd65532);
    if (err) begin
      lat = 1;
      return;
    end
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (!we) begin
      lat = 2;
      nrd = 1;
      word = 0;
      for (int i = 0; i < nbytes; i++) word[8*i +: 8] = ref_mem[adr[15:0] + 16'(i)];
      if (!uns && nbytes < 4 && word[8*nbytes-1])
        for (int i = nbytes; i < 4; i++) word[8*i +: 8] = 8'hFF;
      rd = word;
    end else begin
      lat = (nbytes == 4) ? 2 : 3;
      nrd = (nbytes == 4) ? 0 : 1;
      nwr = 1;
      for (int i = 0; i < nbytes; i++) ref_mem[adr[15:0] + 16'(i)] = wdata[8*i +: 8];
      for (int i = 0; i < 4; i++) din[8*i +: 8] = ref_mem[adr[15:0] + 16'(i)];
    end
  endfunction

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] adr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int nrd, output int nwr, output logic [31:0] din);
    int  rd0, wr0;
    bit  got;
    rd = 0; er = 0; lat = -1; nrd = 0; nwr = 0; din = 0;
    req_we = we; req_size = size; req_unsigned = uns; req_adr = adr; req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) begin
      timeout_fail("req_ready_wait");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rd0 = mrd_cnt;
    wr0 = mwr_cnt;
    got = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        lat = i;
        rd = rsp_rdata;
        er = rsp_err;
      end
    end
    if (!got) timeout_fail("rsp_valid_wait");
    nrd = mrd_cnt - rd0;
    nwr = mwr_cnt - wr0;
    din = last_din;
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input string name, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] adr, input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_lat, input logic [31:0] exp_din);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.adr = adr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_din = exp_din;
    vecs.push_back(v);
  endtask

  task automatic check_resp(input string name, input logic we, input logic [1:0] size,
                            input logic [31:0] rd, input logic er, input int lat,
                            input int nrd, input int nwr, input logic [31:0] din,
                            input logic [31:0] e_rd, input logic e_er, input int e_lat,
                            input logic [31:0] e_din);
    check({name, ".rdata"}, rd, e_rd);
    check({name, ".err"}, 32'(er), 32'(e_er));
    check({name, ".latency"}, 32'(lat), 32'(e_lat));
    check({name, ".mwr_cycles"}, 32'(nwr), (we && !e_er) ? 32'd1 : 32'd0);
    check({name, ".mrd_cycles"}, 32'(nrd),
          (!e_er && !(we && size == 2'b10)) ? 32'd1 : 32'd0);
    if (we && !e_er) check({name, ".mem_din"}, din, e_din);
  endtask

  initial begin
    logic [31:0] rd, e_rd, e_din, din, rd0, a, w;
    logic        er, e_er, we, un;
    logic [1:0]  sz;
    int          lat, nrd, nwr, e_lat, e_nrd, e_nwr, diffs;
    bit          got;

    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    {mem[1003], mem[1002], mem[1001], mem[1000]} = 32'h8899AABB;
    {ref_mem[1003], ref_mem[1002], ref_mem[1001], ref_mem[1000]} = 32'h8899AABB;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_adr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    check("rst.mem_adr", mem_adr, 32'd0);
    check("rst.mem_din", mem_din, 32'd0);
    check("rst.mem_mrd", 32'(mem_mrd), 32'd0);
    check("rst.mem_mwr", 32'(mem_mwr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    addv("lw_1000",   0, 2'd2, 0, 32'd1000, 32'h0,        32'h8899AABB, 0, 2, 32'h0);
    addv("lb_1000",   0, 2'd0, 0, 32'd1000, 32'h0,        32'hFFFFFFBB, 0, 2, 32'h0);
    addv("lbu_1000",  0, 2'd0, 1, 32'd1000, 32'h0,        32'h000000BB, 0, 2, 32'h0);
    addv("lh_1000",   0, 2'd1, 0, 32'd1000, 32'h0,        32'hFFFFAABB, 0, 2, 32'h0);
    addv("lhu_1000",  0, 2'd1, 1, 32'd1000, 32'h0,        32'h0000AABB, 0, 2, 32'h0);
    addv("sb_1000",   1, 2'd0, 0, 32'd1000, 32'h12345677, 32'h0,        0, 3, 32'h8899AA77);
    addv("lw_1000b",  0, 2'd2, 0, 32'd1000, 32'h0,        32'h8899AA77, 0, 2, 32'h0);
    addv("sh_1002",   1, 2'd1, 0, 32'd1002, 32'h0000CAFE, 32'h0,        0, 3, 32'h0000CAFE);
    addv("sw_2000",   1, 2'd2, 0, 32'd2000, 32'h01020304, 32'h0,        0, 2, 32'h01020304);
    addv("lw_1000c",  0, 2'd2, 0, 32'd1000, 32'h0,        32'hCAFEAA77, 0, 2, 32'h0);
    addv("lw_2000",   0, 2'd2, 0, 32'd2000, 32'h0,        32'h01020304, 0, 2, 32'h0);
    addv("lh_2002",   0, 2'd1, 0, 32'd2002, 32'h0,        32'h00000102, 0, 2, 32'h0);
    addv("lw_65532",  0, 2'd2, 0, 32'd65532, 32'h0,       32'h00000000, 0, 2, 32'h0);
    addv("lw_65533",  0, 2'd2, 0, 32'd65533, 32'h0,       32'h00000000, 1, 1, 32'h0);
    addv("sb_huge",   1, 2'd0, 0, 32'hFFFFFFFE, 32'h55,   32'h00000000, 1, 1, 32'h0);
    addv("sw_huge",   1, 2'd2, 0, 32'hFFFFFFFC, 32'h55,   32'h00000000, 1, 1, 32'h0);
    addv("size11",    0, 2'd3, 0, 32'd1000, 32'h0,        32'h00000000, 1, 1, 32'h0);

    foreach (vecs[k]) begin
      run_req(vecs[k].we, vecs[k].size, vecs[k].uns, vecs[k].adr, vecs[k].wdata,
              rd, er, lat, nrd, nwr, din);
      check_resp(vecs[k].name, vecs[k].we, vecs[k].size, rd, er, lat, nrd, nwr, din,
                 vecs[k].exp_rdata, vecs[k].exp_err, vecs[k].exp_lat, vecs[k].exp_din);
      model(vecs[k].we, vecs[k].size, vecs[k].uns, vecs[k].adr, vecs[k].wdata,
            e_rd, e_er, e_lat, e_nrd, e_nwr, e_din);
    end

    // Backpressure: response held for 4 cycles while a second request waits.
    req_we = 0; req_size = 2'd2; req_unsigned = 0; req_adr = 32'd2000; req_wdata = 0;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp.ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_size = 2'd0; req_unsigned = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    if (!got) timeout_fail("bp.rsp_wait");
    rd0 = rsp_rdata;
    check("bp.first_rdata", rd0, 32'h01020304);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp.rsp_valid_held", 32'(rsp_valid), 32'd1);
      check("bp.rdata_stable", rsp_rdata, rd0);
      check("bp.req_ready_low", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp.after_hs_valid", 32'(rsp_valid), 32'd0);
    check("bp.after_hs_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    if (!got) timeout_fail("bp.second_wait");
    check("bp.second_rdata", rsp_rdata, 32'h00000004);
    @(posedge clk); #1;

    // Reset while in WR, before the committing edge.
    req_we = 1; req_size = 2'd2; req_unsigned = 0; req_adr = 32'd3000; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstwr.in_wr", 32'(mem_mwr), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstwr.mem_mwr", 32'(mem_mwr), 32'd0);
    check("rstwr.mem_adr", mem_adr, 32'd0);
    check("rstwr.mem_din", mem_din, 32'd0);
    check("rstwr.req_ready", 32'(req_ready), 32'd1);
    check("rstwr.rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_req(0, 2'd2, 0, 32'd3000, 32'h0, rd, er, lat, nrd, nwr, din);
    check_resp("rstwr.lw_3000", 0, 2'd2, rd, er, lat, nrd, nwr, din, 32'h0, 0, 2, 32'h0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      un = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = 32'd65528 + 32'($urandom_range(0, 7));
        1:       a = $urandom | 32'h8000_0000;
        default: a = 32'd4096 + 32'($urandom_range(0, 31));
      endcase
      w = $urandom;
      run_req(we, sz, un, a, w, rd, er, lat, nrd, nwr, din);
      model(we, sz, un, a, w, e_rd, e_er, e_lat, e_nrd, e_nwr, e_din);
      check_resp($sformatf("rnd%0d", n), we, sz, rd, er, lat, nrd, nwr, din,
                 e_rd, e_er, e_lat, e_din);
    end

    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image_diffs", 32'(diffs), 32'd0);
    check("rd_wr_overlap", 32'(overlap_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
